// File: rtl/trig_link_pkg.sv
// Shared types and default sizes for the trigger-link receiver and its event queue.
package trig_link_pkg;

    localparam int TRIG_TS_W       = 56;
    localparam int TRIG_WID_W      = 8;
    localparam int TRIG_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [TRIG_TS_W-1:0]  ts;
        logic [TRIG_WID_W-1:0] width;
    } trig_evt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH    = 2'd1,
        HOLDOFF = 2'd2
    } rx_state_t;

endpackage

// File: rtl/trig_evt_fifo.sv
// First-word fall-through event queue with occupancy output.
// A pop in the same cycle as a push frees room, so a push into a full queue succeeds when popped.
module trig_evt_fifo
    import trig_link_pkg::*;
#(
    parameter type T          = trig_evt_t,
    parameter int  DEPTH      = TRIG_FIFO_DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        push,
    input  T            push_data,
    output logic        push_ok,
    input  logic        pop,
    output T            head,
    output logic        head_valid,
    output logic [AW:0] count
);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           pop_ok;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign head_valid = !empty;

    // Empty queue presents an all-zero head rather than stale storage.
    always_comb begin
        head = mem[rd_ptr];
        if (empty) begin
            head = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trig_link_receiver.sv
// Digitizer end of the trigger coax link: validates pulses, timestamps and queues them, drives busy.
// Define TRIG_STATS_EN to compile in the 32-bit saturating stat_* counters.
//
// state   | meaning
// IDLE    | waiting for a synchronized rising edge
// HIGH    | measuring pulse width until the falling edge
// HOLDOFF | post-pulse veto window, new edges ignored
module trig_link_receiver
    import trig_link_pkg::*;
#(
    parameter int  TS_W       = TRIG_TS_W,
    parameter int  FIFO_DEPTH = TRIG_FIFO_DEPTH,
    parameter int  WID_W      = TRIG_WID_W,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             trig_in,
    input  logic             busy_req,
    input  logic             reset_ts,
    input  logic [WID_W-1:0] min_width,
    input  logic [15:0]      holdoff,
    output logic             busy_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_ts,
    output logic [WID_W-1:0] evt_width,
    output logic [CW-1:0]    fifo_count
`ifdef TRIG_STATS_EN
    ,
    output logic [31:0]      stat_acc_cnt,
    output logic [31:0]      stat_short_cnt,
    output logic [31:0]      stat_drop_cnt,
    output logic [31:0]      stat_overlap_cnt
`endif
);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WID_W-1:0] width;
    } evt_t;

    logic             sync_1;
    logic             sync_2;
    logic             trig_lvl;
    logic             rise_det;
    logic             fall_det;
    logic [TS_W-1:0]  ts_cnt;

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [TS_W-1:0]  ts_lat;
    logic [TS_W-1:0]  ts_lat_nxt;
    logic [WID_W-1:0] width;
    logic [WID_W-1:0] width_nxt;
    logic [15:0]      hold_cnt;
    logic [15:0]      hold_cnt_nxt;
    logic [WID_W-1:0] min_eff;
    logic             push;
    logic             push_ok;
    logic             short_evt;
    logic             overlap_evt;
    logic             drop_evt;
    evt_t             push_data;
    evt_t             head;

    // Front end resets high so a pulse already present at reset release needs a fresh edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            trig_lvl <= 1'b1;
            rise_det <= 1'b0;
            fall_det <= 1'b0;
        end else begin
            sync_1   <= trig_in;
            sync_2   <= sync_1;
            trig_lvl <= sync_2;
            rise_det <= sync_2 & ~trig_lvl;
            fall_det <= ~sync_2 & trig_lvl;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ts_cnt <= '0;
        end else if (reset_ts) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    assign min_eff = (min_width == '0) ? WID_W'(1) : min_width;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            ts_lat   <= '0;
            width    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ts_lat   <= ts_lat_nxt;
            width    <= width_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ts_lat_nxt   = ts_lat;
        width_nxt    = width;
        hold_cnt_nxt = hold_cnt;
        push         = 1'b0;
        short_evt    = 1'b0;
        overlap_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (rise_det) begin
                    ts_lat_nxt = ts_cnt;
                    width_nxt  = WID_W'(1);
                    state_nxt  = HIGH;
                end
            end
            HIGH: begin
                if (fall_det) begin
                    if (width >= min_eff) begin
                        push = 1'b1;
                        if (holdoff == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            hold_cnt_nxt = holdoff;
                            state_nxt    = HOLDOFF;
                        end
                    end else begin
                        short_evt = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (trig_lvl && !(&width)) begin
                    width_nxt = width + 1'b1;
                end
            end
            HOLDOFF: begin
                if (rise_det) begin
                    overlap_evt = 1'b1;
                end
                // Terminal count at 1 gives exactly `holdoff` cycles in this state.
                hold_cnt_nxt = hold_cnt - 16'd1;
                if (hold_cnt <= 16'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign push_data = '{ts: ts_lat, width: width};
    assign drop_evt  = push && !push_ok;

    trig_evt_fifo #(
        .T     (evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .push       (push),
        .push_data  (push_data),
        .push_ok    (push_ok),
        .pop        (evt_ready),
        .head       (head),
        .head_valid (evt_valid),
        .count      (fifo_count)
    );

    assign evt_ts    = head.ts;
    assign evt_width = head.width;

    // Busy resets high: the trigger board sees "not ready" until the receiver is running.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_out <= 1'b1;
        end else begin
            busy_out <= (state != IDLE) || busy_req || rise_det ||
                        (fifo_count >= CW'(FIFO_DEPTH - 1));
        end
    end

`ifdef TRIG_STATS_EN
    logic [31:0] acc_cnt;
    logic [31:0] short_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] overlap_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_cnt     <= '0;
            short_cnt   <= '0;
            drop_cnt    <= '0;
            overlap_cnt <= '0;
        end else if (reset_ts) begin
            acc_cnt     <= '0;
            short_cnt   <= '0;
            drop_cnt    <= '0;
            overlap_cnt <= '0;
        end else begin
            if (push_ok && !(&acc_cnt)) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
            if (short_evt && !(&short_cnt)) begin
                short_cnt <= short_cnt + 32'd1;
            end
            if (drop_evt && !(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (overlap_evt && !(&overlap_cnt)) begin
                overlap_cnt <= overlap_cnt + 32'd1;
            end
        end
    end

    assign stat_acc_cnt     = acc_cnt;
    assign stat_short_cnt   = short_cnt;
    assign stat_drop_cnt    = drop_cnt;
    assign stat_overlap_cnt = overlap_cnt;
`else
    logic stats_unused;
    assign stats_unused = short_evt ^ overlap_evt ^ drop_evt;
`endif

endmodule
